photon_window_counter: RTL and testbench

- Upstream stage of the per-pattern data memory in the single-pixel imaging chain.
- Counts photon-detector pulses while each DMD pattern is displayed, i.e. while DMD_sig is high.
- At the end of each pattern window it presents a stable count on count_out. The memory captures that count on the next DMD_sig rising edge.
- Also provides a window index and handshake flags for the host/readout logic.

---
 rtl/photon_window_counter.sv | 154 +++++++++++++++
 tb/tb_photon_window_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/photon_window_counter.sv
// Photon counter gated by the DMD pattern-valid window; presents one stable count per pattern.
// Optional macro PHOTON_OVERFLOW_FLAG_EN adds a per-window saturation flag on port overflow.
module photon_window_counter #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEADTIME_CYCLES = 2,
  parameter int unsigned IDX_WIDTH       = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 photon_in,
  input  logic                 DMD_sig,
  output logic [WIDTH-1:0]     count_out,
  output logic                 count_valid,
  output logic [IDX_WIDTH-1:0] frame_idx,
`ifdef PHOTON_OVERFLOW_FLAG_EN
  output logic                 overflow,
`endif
  output logic                 busy
);

  localparam int unsigned ST_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DT_W        = (DEADTIME_CYCLES > 0) ? $clog2(DEADTIME_CYCLES + 1) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    LATCH  = 2'd3
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] ph_sync;
  logic [SYNC_STAGES-1:0] dmd_sync;
  logic [WIDTH-1:0]       acc;
  logic [ST_W-1:0]        settle_cnt;
  logic [DT_W-1:0]        dead_cnt;

  logic ph_rise_c;
  logic dmd_rise_c;
  logic dmd_fall_c;
  logic photon_acc_c;
  logic acc_full_c;

  // Bit 0 is the newest sample; edges come from the two oldest stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_sync  <= '0;
      dmd_sync <= '0;
    end else begin
      ph_sync  <= {ph_sync[SYNC_STAGES-2:0], photon_in};
      dmd_sync <= {dmd_sync[SYNC_STAGES-2:0], DMD_sig};
    end
  end

  assign ph_rise_c    = ph_sync[SYNC_STAGES-2] & ~ph_sync[SYNC_STAGES-1];
  assign dmd_rise_c   = dmd_sync[SYNC_STAGES-2] & ~dmd_sync[SYNC_STAGES-1];
  assign dmd_fall_c   = ~dmd_sync[SYNC_STAGES-2] & dmd_sync[SYNC_STAGES-1];
  assign photon_acc_c = (state == COUNT) && ph_rise_c && (dead_cnt == '0);
  assign acc_full_c   = (acc == {WIDTH{1'b1}});

  // Detector deadtime: only photons actually counted re-arm the hold-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      dead_cnt <= '0;
    end else if (photon_acc_c) begin
      dead_cnt <= DT_W'(DEADTIME_CYCLES);
    end else if (dead_cnt != '0) begin
      dead_cnt <= dead_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      settle_cnt  <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      frame_idx   <= '0;
      busy        <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (dmd_rise_c) begin
            acc        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            if (SETTLE_CYCLES == 0) begin
              state <= COUNT;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (dmd_fall_c) begin
            state <= LATCH;
            busy  <= 1'b0;
          end else if (settle_cnt == ST_W'(SETTLE_LAST)) begin
            state <= COUNT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        COUNT: begin
          if (photon_acc_c && !acc_full_c) begin
            acc <= acc + 1'b1;
          end
          if (dmd_fall_c) begin
            state <= LATCH;
            busy  <= 1'b0;
          end
        end
        LATCH: begin
          count_out   <= acc;
          count_valid <= 1'b1;
          frame_idx   <= frame_idx + 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHOTON_OVERFLOW_FLAG_EN
  logic ovf_flag;

  // Sticky per-window flag, published together with count_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if ((state == IDLE) && dmd_rise_c) begin
        ovf_flag <= 1'b0;
      end else if (photon_acc_c && acc_full_c) begin
        ovf_flag <= 1'b1;
      end
      if (state == LATCH) begin
        overflow <= ovf_flag;
      end
    end
  end
`endif

endmodule

// File: tb/tb_photon_window_counter.sv
// Directed bench for photon_window_counter with an expected-result queue drained by a count_valid monitor.
module tb_photon_window_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          photon_in;
  logic          DMD_sig;
  logic [W-1:0]  count_out;
  logic          count_valid;
  logic [IW-1:0] frame_idx;
  logic          busy;
`ifdef PHOTON_OVERFLOW_FLAG_EN
  logic          overflow;
`endif

  typedef struct packed {
    logic [W-1:0]  cnt;
    logic [IW-1:0] idx;
    logic          ovf;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [IW-1:0] exp_idx;
  int            checks = 0;
  int            errors = 0;
  int            valid_seen = 0;

  photon_window_counter #(
    .WIDTH(W), .SYNC_STAGES(3), .SETTLE_CYCLES(4), .DEADTIME_CYCLES(2), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .photon_in(photon_in),
    .DMD_sig(DMD_sig),
    .count_out(count_out),
    .count_valid(count_valid),
    .frame_idx(frame_idx),
`ifdef PHOTON_OVERFLOW_FLAG_EN
    .overflow(overflow),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int spacing);
    photon_in = 1'b1;
    tick(1);
    photon_in = 1'b0;
    tick(spacing - 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    exp_idx = '0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      tick(1);
      k++;
    end
    check("valid_timeout", exp_q.size(), 0);
  endtask

  // One pattern window: settle-phase pulses, then counted pulses, then DMD_sig falls.
  task automatic window(input int n_settle, input int n_ph, input int spacing,
                        input int exp_cnt, input logic exp_ovf, input bit drain);
    exp_t e;
    DMD_sig = 1'b1;
    tick(1);
    for (int i = 0; i < n_settle; i++) pulse(2);
    tick(10 - 1 - 2 * n_settle);
    check("busy_in_window", busy, 1);
    for (int i = 0; i < n_ph; i++) pulse(spacing);
    tick(2);
    DMD_sig = 1'b0;
    exp_idx = exp_idx + 1'b1;
    e.cnt = W'(exp_cnt);
    e.idx = exp_idx;
    e.ovf = exp_ovf;
    exp_q.push_back(e);
    if (drain) begin
      wait_drain();
      check("busy_after", busy, 0);
    end else begin
      tick(3);
    end
  endtask

  // Scoreboard side: every count_valid must match the next queued window result.
  always @(negedge clk) begin
    if (rst === 1'b0 && count_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("count_out", count_out, mon_e.cnt);
        check("frame_idx", frame_idx, mon_e.idx);
`ifdef PHOTON_OVERFLOW_FLAG_EN
        check("overflow", overflow, mon_e.ovf);
`endif
      end
    end
  end

  initial begin
    int vs;
    photon_in = 1'b0;
    DMD_sig   = 1'b0;
    do_reset(2);
    check("rst_count_out", count_out, 0);
    check("rst_count_valid", count_valid, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_busy", busy, 0);

    // Basic window: 5 photons spaced 10
    window(0, 5, 10, 5, 1'b0, 1'b1);
    // Settle masking: 2 pulses in settle are dropped
    window(2, 3, 10, 3, 1'b0, 1'b1);
    // Deadtime: spacing 2 keeps every other, spacing 3 keeps all
    window(0, 10, 2, 5, 1'b0, 1'b1);
    window(0, 10, 3, 10, 1'b0, 1'b1);
    // Saturation at 4 bits, then recovery
    window(0, 20, 4, 15, 1'b1, 1'b1);
    window(0, 2, 4, 2, 1'b0, 1'b1);

    // Reset one cycle before DMD_sig falls: the window is discarded
    DMD_sig = 1'b1;
    tick(10);
    for (int i = 0; i < 7; i++) pulse(3);
    tick(1);
    vs = valid_seen;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    DMD_sig = 1'b0;
    exp_idx = '0;
    check("midrst_count_out", count_out, 0);
    check("midrst_frame_idx", frame_idx, 0);
    check("midrst_busy", busy, 0);
    tick(10);
    check("midrst_no_valid", valid_seen, vs);
    window(0, 3, 3, 3, 1'b0, 1'b1);

    // Back-to-back windows with index wrap
    do_reset(2);
    for (int n = 1; n <= 5; n++) window(0, n, 3, n, 1'b0, 1'b0);
    wait_drain();
    check("final_frame_idx", frame_idx, 1);
    check("final_count_out", count_out, 5);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
